// File: rtl/fb_arbiter_pkg.sv
// fb_arbiter_pkg: shared state and grant encodings for the framebuffer arbiter
package fb_arbiter_pkg;
    typedef enum logic {IDLE, CLEAR} state_t;
    typedef enum logic [1:0] {NONE, DISP, CLR, WR} grant_t;
endpackage

// File: rtl/fb_clear_seq.sv
// fb_clear_seq: fill-sweep FSM and address counter; the sweep pauses on stall
module fb_clear_seq
    import fb_arbiter_pkg::*;
#(
    parameter int n_words = 307200,
    parameter int w_addr  = 19,
    parameter int w_data  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic [w_data-1:0] clear_color,
    input  logic              stall,
    output logic              busy,
    output logic [w_addr-1:0] addr,
    output logic [w_data-1:0] color
);
    localparam logic [w_addr-1:0] last = w_addr'(n_words - 1);
    state_t state;
    assign busy = state == CLEAR;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            color <= '0;
        end else if (state == IDLE) begin
            if (clear_req) begin
                state <= CLEAR;
                addr  <= '0;
                color <= clear_color;
            end
        end else if (!stall) begin
            if (addr == last) state <= IDLE;
            else addr <= addr + 1'b1;
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter (display read > clear fill > writer).
// Define FB_ARBITER_STATS_EN to add the saturating wr_stall_cnt output.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int clk_mhz       = 50,
    parameter int pixel_mhz     = 25,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int w_data        = 12,
    parameter int w_addr        = $clog2(screen_width * screen_height)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_strobe,
    input  logic              display_on,
    input  logic [w_x-1:0]    pix_x,
    input  logic [w_y-1:0]    pix_y,
    output logic [w_data-1:0] pix_rgb,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [w_x-1:0]    wr_x,
    input  logic [w_y-1:0]    wr_y,
    input  logic [w_data-1:0] wr_data,
    input  logic              clear_req,
    input  logic [w_data-1:0] clear_color,
    output logic              clear_busy,
    output logic [w_addr-1:0] mem_addr,
    output logic              mem_we,
    output logic [w_data-1:0] mem_wdata,
    input  logic [w_data-1:0] mem_rdata
`ifdef FB_ARBITER_STATS_EN
    ,
    output logic [15:0]       wr_stall_cnt
`endif
);
    if (clk_mhz % pixel_mhz != 0 || clk_mhz / pixel_mhz < 2) begin : g_bad_ratio
        $error("fb_arbiter: clk_mhz/pixel_mhz must be an integer of at least 2");
    end
    grant_t grant;
    logic disp_rd, wr_in, rd_v, rd_on;
    logic [w_addr-1:0] disp_addr, wr_addr, clr_addr, addr_q;
    logic [w_data-1:0] clr_color;
    assign disp_rd   = pix_strobe & display_on;
    assign wr_ready  = ~rst & ~disp_rd & ~clear_busy;
    assign disp_addr = w_addr'(pix_y) * w_addr'(screen_width) + w_addr'(pix_x);
    assign wr_addr   = w_addr'(wr_y) * w_addr'(screen_width) + w_addr'(wr_x);
    assign wr_in     = ({1'b0, wr_x} < (w_x + 1)'(screen_width)) && ({1'b0, wr_y} < (w_y + 1)'(screen_height));
    fb_clear_seq #(
        .n_words(screen_width * screen_height),
        .w_addr (w_addr),
        .w_data (w_data)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .clear_color(clear_color),
        .stall      (disp_rd),
        .busy       (clear_busy),
        .addr       (clr_addr),
        .color      (clr_color)
    );
    always_comb begin
        grant     = rst ? NONE : disp_rd ? DISP : clear_busy ? CLR : (wr_valid & wr_ready) ? WR : NONE;
        mem_addr  = grant == DISP ? disp_addr : grant == CLR ? clr_addr : grant == WR ? wr_addr : addr_q;
        mem_we    = grant == CLR || (grant == WR && wr_in);
        mem_wdata = grant == CLR ? clr_color : wr_data;
    end
    // read issued at N returns data at N+1, registered into pix_rgb for N+2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v    <= 1'b0;
            rd_on   <= 1'b0;
            pix_rgb <= '0;
            addr_q  <= '0;
        end else begin
            rd_v   <= pix_strobe;
            rd_on  <= display_on;
            addr_q <= mem_addr;
            if (rd_v) pix_rgb <= rd_on ? mem_rdata : '0;
        end
    end
`ifdef FB_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_stall_cnt <= '0;
        else if (wr_valid && !wr_ready && wr_stall_cnt != 16'hFFFF) wr_stall_cnt <= wr_stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed scoreboard bench for fb_arbiter on a 640x8 framebuffer
module tb_fb_arbiter;
    localparam int W = 640, H = 8, N = W * H;
    localparam int XW = 10, YW = 3, AW = 13, DW = 12;
    logic clk, rst, pix_strobe, display_on, wr_valid, wr_ready, clear_req, clear_busy, mem_we;
    logic [XW-1:0] pix_x, wr_x;
    logic [YW-1:0] pix_y, wr_y;
    logic [DW-1:0] pix_rgb, wr_data, clear_color, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
`ifdef FB_ARBITER_STATS_EN
    logic [15:0] wr_stall_cnt;
`endif
    logic [DW-1:0] ram [0:N-1];
    int checks = 0, errors = 0, cyc = 0;
    typedef struct {int due; logic [DW-1:0] val;} exp_t;
    exp_t sb[$];

    fb_arbiter #(.screen_width(W), .screen_height(H)) dut (
        .clk(clk), .rst(rst), .pix_strobe(pix_strobe), .display_on(display_on),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FB_ARBITER_STATS_EN
        , .wr_stall_cnt(wr_stall_cnt)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // single-port RAM with one-cycle read latency; word k preloaded with k, word 1283 with 0xABC
    initial begin
        for (int i = 0; i < N; i++) ram[i] = DW'(i);
        ram[1283] = 12'hABC;
        forever begin
            @(posedge clk);
            mem_rdata <= (int'(mem_addr) < N) ? ram[mem_addr] : '0;
            if (mem_we && int'(mem_addr) < N) ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk(sb[0].due == cyc ? "pix_rgb" : "pix_rgb_late", {20'h0, pix_rgb}, {20'h0, sb[0].val});
            void'(sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            pix_strobe = 0;
            clear_req = 0;
        end
    endtask

    task automatic rd(input int x, input int y, input logic [DW-1:0] v);
        step();
        pix_strobe = 1;
        display_on = 1;
        pix_x = XW'(x);
        pix_y = YW'(y);
        sb.push_back('{cyc + 2, v});
        #3;
        chk("rd_addr", mem_addr, y * W + x);
    endtask

    int nxt, last_cyc, fall_cyc, rdy_bad, we_bad, seq_bad, ram_bad, xw;
    bit done;

    initial begin
        rst = 1; pix_strobe = 0; display_on = 0; pix_x = 0; pix_y = 0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = 0; clear_req = 0; clear_color = 0;
        repeat (3) step();
        #3;
        chk("rst_busy", clear_busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pix", pix_rgb, 0);
        chk("rst_ready", wr_ready, 0);
        step();
        rst = 0;
        #3;
        chk("idle_ready", wr_ready, 1);
        chk("idle_we", mem_we, 0);
        // display read of (3,2) -> word 1283
        rd(3, 2, 12'hABC);
        chk("rd_ready", wr_ready, 0);
        idle(4);
        #3;
        chk("pix_hold", pix_rgb, 12'hABC);
        step();
        pix_strobe = 1;
        display_on = 0;
        sb.push_back('{cyc + 2, 12'h000});
        idle(4);
        #3;
        chk("blank_hold", pix_rgb, 0);
        // writer held valid while strobes arrive every second cycle
        xw = 10;
        for (int i = 0; i < 12; i++) begin
            step();
            pix_strobe = (i % 2 == 0);
            display_on = 1;
            pix_x = XW'(i);
            pix_y = 1;
            wr_valid = 1;
            wr_x = XW'(xw);
            wr_y = 5;
            wr_data = DW'(12'h100 + xw);
            #3;
            if (i % 2 == 0) begin
                sb.push_back('{cyc + 2, DW'(W + i)});
                chk("il_ready0", wr_ready, 0);
                chk("il_we0", mem_we, 0);
                chk("il_raddr", mem_addr, W + i);
            end else begin
                chk("il_ready1", wr_ready, 1);
                chk("il_we1", mem_we, 1);
                chk("il_waddr", mem_addr, 5 * W + xw);
                chk("il_wdata", mem_wdata, 12'h100 + xw);
                xw++;
            end
        end
        step();
        pix_strobe = 0;
        wr_valid = 0;
        for (int k = 10; k < 16; k++) rd(k, 5, DW'(12'h100 + k));
        // out-of-range column is consumed without a RAM write
        step();
        pix_strobe = 0;
        wr_valid = 1;
        wr_x = XW'(W);
        wr_y = 0;
        wr_data = 12'h777;
        #3;
        chk("oob_ready", wr_ready, 1);
        chk("oob_we", mem_we, 0);
        step();
        wr_valid = 0;
        rd(0, 1, DW'(W));
        idle(3);
        // clear request together with a write: write first, sweep next cycle
        step();
        pix_strobe = 0;
        wr_valid = 1;
        wr_x = 7;
        wr_y = 7;
        wr_data = 12'h5A5;
        clear_req = 1;
        clear_color = 12'hF00;
        #3;
        chk("cw_busy0", clear_busy, 0);
        chk("cw_we", mem_we, 1);
        chk("cw_addr", mem_addr, 7 * W + 7);
        nxt = 0; last_cyc = -100; fall_cyc = 0; rdy_bad = 0; we_bad = 0; seq_bad = 0; done = 0;
        for (int c = 0; c < 30000 && !done; c++) begin
            step();
            pix_strobe = (c % 4 == 1);
            display_on = 1;
            pix_x = XW'(c % W);
            pix_y = YW'(c % H);
            wr_valid = 1;
            wr_x = 1;
            wr_y = 1;
            wr_data = 12'h0AA;
            clear_req = (c == 100);
            clear_color = (c == 100) ? 12'h00F : 12'hF00;
            #3;
            if (c == 0) chk("cw_busy1", clear_busy, 1);
            if (!clear_busy) begin
                done = 1;
                fall_cyc = cyc;
            end else begin
                if (wr_ready) rdy_bad++;
                if (pix_strobe) begin
                    if (mem_we) we_bad++;
                end else if (!mem_we || int'(mem_addr) != nxt || mem_wdata != 12'hF00) seq_bad++;
                else begin
                    if (nxt == N - 1) last_cyc = cyc;
                    nxt++;
                end
            end
        end
        ram_bad = 0;
        for (int i = 0; i < N; i++) if (ram[i] != 12'hF00) ram_bad++;
        chk("clr_done", done, 1);
        chk("clr_count", nxt, N);
        chk("clr_seq_bad", seq_bad, 0);
        chk("clr_ready_bad", rdy_bad, 0);
        chk("clr_strobe_we", we_bad, 0);
        chk("clr_fall_lag", fall_cyc - last_cyc, 1);
        chk("clr_ram_bad", ram_bad, 0);
        step();
        pix_strobe = 0;
        clear_req = 0;
        #3;
        chk("post_ready", wr_ready, 1);
        chk("post_addr", mem_addr, W + 1);
        step();
        wr_valid = 0;
        rd(3, 2, 12'hF00);
        rd(1, 1, 12'h0AA);
        idle(4);
        // reset in the middle of a sweep
        step();
        clear_req = 1;
        clear_color = 12'h0F0;
        idle(50);
        #3;
        chk("mid_busy", clear_busy, 1);
        step();
        rst = 1;
        #1;
        chk("mr_busy", clear_busy, 0);
        chk("mr_we", mem_we, 0);
        chk("mr_addr", mem_addr, 0);
        step();
        rst = 0;
        #3;
        chk("mr_idle_busy", clear_busy, 0);
        chk("mr_idle_ready", wr_ready, 1);
        idle(3);
        #3;
        chk("mr_still_idle", clear_busy, 0);
        rd(0, 0, 12'h0F0);
        rd(W - 1, H - 1, 12'hF00);
        idle(4);
`ifdef FB_ARBITER_STATS_EN
        chk("st_zero", wr_stall_cnt, 0);
        repeat (10) begin
            step();
            pix_strobe = 1;
            display_on = 1;
            wr_valid = 1;
        end
        step();
        wr_valid = 0;
        pix_strobe = 0;
        #3;
        chk("st_ten", wr_stall_cnt, 10);
        repeat (70000) begin
            step();
            pix_strobe = 1;
            wr_valid = 1;
        end
        step();
        wr_valid = 0;
        pix_strobe = 0;
        #3;
        chk("st_sat", wr_stall_cnt, 16'hFFFF);
        idle(4);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
